// File: rtl/imm_gen_pkg.sv
// ---------------------------------------------------------------------------
// imm_gen_pkg
//   Shared definitions for the immediate generator: immediate-source codes,
//   the skid-buffer state encoding and the XLEN legality helper.
// ---------------------------------------------------------------------------
package imm_gen_pkg;

    // Immediate-source codes as presented on immediate_source.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // Only RV32 and RV64 datapaths are supported.
    function automatic bit xlen_is_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
//   Combinational immediate decoder, shared by the pipelined and the
//   single-cycle datapaths.
//
//   Ports
//     instruction      in   32    raw instruction word, bits [6:0] unused
//     immediate_source in   3     IMM_I..IMM_Z, 110/111 illegal
//     imm              out  XLEN  sign- (or for Z, zero-) extended immediate
//     illegal          out  1     immediate_source was 110/111
// ---------------------------------------------------------------------------
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instruction,
    input  logic [2:0]       immediate_source,
    output logic [XLEN-1:0]  imm,
    output logic             illegal
);

    logic        s;
    logic [31:0] imm32;

    // The opcode field plays no part in immediate extraction.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instruction[6:0];

    assign s = instruction[31];

    // Every format is first assembled as a 32-bit value whose bit 31 is the
    // correct sign (always 0 for Z); widening to XLEN is then one sign
    // extension, which also gives U its RV64 sign extension from bit 31.
    always_comb begin
        // NOTE: default every output first so no path through the case leaves
        // a value unassigned, which would infer a latch.
        imm32   = '0;
        illegal = 1'b0;
        case (immediate_source)
            IMM_I:   imm32 = {{20{s}}, instruction[31:20]};
            IMM_S:   imm32 = {{20{s}}, instruction[31:25], instruction[11:7]};
            IMM_B:   imm32 = {{19{s}}, s, instruction[7], instruction[30:25],
                              instruction[11:8], 1'b0};
            IMM_U:   imm32 = {instruction[31:12], 12'b0};
            IMM_J:   imm32 = {{11{s}}, s, instruction[19:12], instruction[20],
                              instruction[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, instruction[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator for the decode stage. Decodes the
//   immediate, computes target = pc + imm, and buffers results behind a
//   valid/ready handshake with a two-entry skid buffer so a full-rate stream
//   passes while in_ready stays a pure register output.
//
//   Ports
//     clk                  in   1     rising-edge clock
//     reset                in   1     asynchronous, active-high
//     flush                in   1     synchronous, drops all buffered entries
//     in_valid / in_ready  in/out     upstream handshake
//     instruction          in   32    instruction word
//     immediate_source     in   3     immediate format code
//     pc                   in   XLEN  instruction address
//     out_valid / out_ready out/in    downstream handshake
//     immediate_extension  out  XLEN  extended immediate
//     target               out  XLEN  pc + immediate, wrapping
//     imm_illegal          out  1     immediate_source was 110/111
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [2:0]       immediate_source,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immediate_extension,
    output logic [XLEN-1:0]  target,
    output logic             imm_illegal
);

    if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    buf_state_e state_q, state_d;
    entry_t     main_q, skid_q;
    entry_t     in_entry;

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            accept, consume;
    logic            load_main_in, load_main_skid, load_skid;

    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .instruction      (instruction),
        .immediate_source (immediate_source),
        .imm              (dec_imm),
        .illegal          (dec_illegal)
    );

    assign in_entry.imm     = dec_imm;
    assign in_entry.target  = pc + dec_imm;
    assign in_entry.illegal = dec_illegal;

    // Both handshake outputs come straight from the state register.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Flush wins over any handshake in the same cycle; the input
            // presented now is dropped along with the buffered entries.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data only moves on a handshake, so an X instruction presented while
    // in_valid is low never reaches a register.
    // NOTE: these are two plain registers, not a memory array, so they take
    // the async reset and the outputs read zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign immediate_extension = main_q.imm;
    assign target              = main_q.target;
    assign imm_illegal         = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
//   compares both against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [2:0]  imm_src;
    logic [63:0] pc;

    logic        ir32, ov32, ill32;
    logic [31:0] imm32, tgt32;
    logic        ir64, ov64, ill64;
    logic [63:0] imm64, tgt64;

    imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .in_valid            (in_valid),
        .in_ready            (ir32),
        .instruction         (instruction),
        .immediate_source    (imm_src),
        .pc                  (pc[31:0]),
        .out_valid           (ov32),
        .out_ready           (out_ready),
        .immediate_extension (imm32),
        .target              (tgt32),
        .imm_illegal         (ill32)
    );

    imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .in_valid            (in_valid),
        .in_ready            (ir64),
        .instruction         (instruction),
        .immediate_source    (imm_src),
        .pc                  (pc),
        .out_valid           (ov64),
        .out_ready           (out_ready),
        .immediate_extension (imm64),
        .target              (tgt64),
        .imm_illegal         (ill64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    exp_t model_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Immediate value computed from the format tables as signed field values.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [2:0] src,
                                        input logic [63:0] p);
        exp_t        e;
        logic [11:0] f12;
        logic [12:0] f13;
        logic [20:0] f21;
        logic [31:0] f32;
        e.pc  = p;
        e.ill = 1'b0;
        e.imm = '0;
        case (src)
            3'd0: begin f12 = ins[31:20];                e.imm = 64'(signed'(f12)); end
            3'd1: begin f12 = {ins[31:25], ins[11:7]};   e.imm = 64'(signed'(f12)); end
            3'd2: begin
                f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                e.imm = 64'(signed'(f13));
            end
            3'd3: begin f32 = {ins[31:12], 12'h000};     e.imm = 64'(signed'(f32)); end
            3'd4: begin
                f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                e.imm = 64'(signed'(f21));
            end
            3'd5: e.imm = 64'(ins[19:15]);
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic compare_outputs();
        int          n;
        exp_t        e;
        logic [31:0] t32;
        n = model_q.size();
        check("in_ready32", 64'(ir32), 64'(n < 2));
        check("in_ready64", 64'(ir64), 64'(n < 2));
        check("out_valid32", 64'(ov32), 64'(n > 0));
        check("out_valid64", 64'(ov64), 64'(n > 0));
        if (n > 0) begin
            e   = model_q[0];
            t32 = e.pc[31:0] + e.imm[31:0];
            check("imm32", 64'(imm32), 64'(e.imm[31:0]));
            check("target32", 64'(tgt32), 64'(t32));
            check("illegal32", 64'(ill32), 64'(e.ill));
            check("imm64", imm64, e.imm);
            check("target64", tgt64, e.pc + e.imm);
            check("illegal64", 64'(ill64), 64'(e.ill));
        end
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src,
                        input logic [63:0] p, input logic ordy, input logic fl);
        logic acc, con;
        compare_outputs();
        in_valid    = v;
        instruction = v ? ins : 'x;
        imm_src     = src;
        pc          = p;
        out_ready   = ordy;
        flush       = fl;
        acc = v && (model_q.size() < 2);
        con = ordy && (model_q.size() > 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (con) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(ins, src, p));
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 3'd0, 64'h0, ordy, 1'b0);
    endtask

    task automatic fill_full();
        step(1'b1, 32'h00100093, 3'd0, 64'h10, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 3'd0, 64'h20, 1'b0, 1'b0);
        check("fill_full_ready", 64'(ir32), 64'(0));
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = '0;
        imm_src     = '0;
        pc          = '0;

        @(negedge clk);
        check("rst_out_valid", 64'(ov32), 64'(0));
        check("rst_in_ready", 64'(ir32), 64'(1));
        check("rst_imm", imm64, 64'h0);
        check("rst_target", tgt64, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // I-type, available one cycle after acceptance.
        step(1'b1, 32'hFFF00093, 3'd0, 64'h0, 1'b1, 1'b0);
        check("t1_imm", 64'(imm32), 64'hFFFFFFFF);
        check("t1_target", 64'(tgt32), 64'hFFFFFFFF);
        step(1'b1, 32'hFE000EE3, 3'd2, 64'h100, 1'b1, 1'b0);
        check("t2_b_imm", 64'(imm32), 64'hFFFFFFFC);
        check("t2_b_target", 64'(tgt32), 64'h000000FC);
        step(1'b1, 32'h008000EF, 3'd4, 64'h100, 1'b1, 1'b0);
        check("t2_j_imm", 64'(imm32), 64'h8);
        check("t2_j_target", 64'(tgt32), 64'h108);
        step(1'b1, 32'h800000B7, 3'd3, 64'h0, 1'b1, 1'b0);
        check("t3_u_imm64", imm64, 64'hFFFFFFFF80000000);
        step(1'b1, 32'h000FD073, 3'd5, 64'h0, 1'b1, 1'b0);
        check("t3_z_imm64", imm64, 64'h1F);
        step(1'b1, 32'hFFFFFFFF, 3'd7, 64'h40, 1'b1, 1'b0);
        check("t3_illegal_imm", imm64, 64'h0);
        check("t3_illegal_flag", 64'(ill64), 64'(1));
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: A and B taken, C held until space opens.
        step(1'b1, 32'h00A00093, 3'd0, 64'hA00, 1'b0, 1'b0);
        step(1'b1, 32'h00B00093, 3'd0, 64'hB00, 1'b0, 1'b0);
        step(1'b1, 32'h00C00093, 3'd0, 64'hC00, 1'b0, 1'b0);
        check("t4_c_held", 64'(ir32), 64'(0));
        step(1'b1, 32'h00C00093, 3'd0, 64'hC00, 1'b1, 1'b0);
        step(1'b1, 32'h00C00093, 3'd0, 64'hC00, 1'b1, 1'b0);
        check("t4_c_front", 64'(imm32), 64'hC);
        idle(1'b1);
        idle(1'b1);

        // Flush while FULL with a simultaneous offer.
        fill_full();
        step(1'b1, 32'h00D00093, 3'd0, 64'hD00, 1'b1, 1'b1);
        check("t5_flush_valid", 64'(ov32), 64'(0));
        check("t5_flush_ready", 64'(ir32), 64'(1));
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset while FULL.
        fill_full();
        compare_outputs();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_async_valid32", 64'(ov32), 64'(0));
        check("t6_async_valid64", 64'(ov64), 64'(0));
        check("t6_async_ready", 64'(ir32), 64'(1));
        check("t6_async_imm", imm64, 64'h0);
        model_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Full-rate streaming: one result per cycle.
        for (int i = 0; i < 24; i++) begin
            step(1'b1, $urandom, 3'($urandom_range(0, 5)), {$urandom, $urandom}, 1'b1, 1'b0);
            if (i > 0) check("t6_stream_valid", 64'(ov32), 64'(1));
        end
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        compare_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
